// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low GFEDCBA glyphs, blank codes and
// the receiver's phase-settle state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_NUM0  = 7'h40;
  localparam logic [6:0] SEG_NUM1  = 7'h79;
  localparam logic [6:0] SEG_NUM2  = 7'h24;
  localparam logic [6:0] SEG_NUM3  = 7'h30;
  localparam logic [6:0] SEG_NUM4  = 7'h19;
  localparam logic [6:0] SEG_NUM5  = 7'h12;
  localparam logic [6:0] SEG_NUM6  = 7'h02;
  localparam logic [6:0] SEG_NUM7  = 7'h78;
  localparam logic [6:0] SEG_NUM8  = 7'h00;
  localparam logic [6:0] SEG_NUM9  = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    ST_SETTLE   = 1'b0,
    ST_CAPTURED = 1'b1
  } rx_state_e;

  // One snapshot of the multiplexed bus.
  typedef struct packed {
    logic       sel;
    logic [6:0] pins;
  } bus_sample_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] bcd;
  } seg_dec_t;

  localparam bus_sample_t BUS_IDLE = '{sel: 1'b0, pins: SEG_BLANK};

endpackage

// File: rtl/seg7_mux_receiver_if.sv
// Bus-side and result-side signals of the multiplexed seven-segment receiver.
interface seg7_mux_receiver_if;

  logic       i_digit_sel;
  logic [6:0] i_digit_pins;
  logic [3:0] o_digit_tens;
  logic [3:0] o_digit_ones;
  logic [1:0] o_blank;
  logic       o_valid;
  logic       o_update;
  logic       o_error;

  modport slave (
    input  i_digit_sel,
    input  i_digit_pins,
    output o_digit_tens,
    output o_digit_ones,
    output o_blank,
    output o_valid,
    output o_update,
    output o_error
  );

  modport master (
    output i_digit_sel,
    output i_digit_pins,
    input  o_digit_tens,
    input  o_digit_ones,
    input  o_blank,
    input  o_valid,
    input  o_update,
    input  o_error
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational inverse of the display driver's glyph table: active-low
// GFEDCBA pattern to BCD, with blank and illegal-pattern flags.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pins_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec_o = '{legal: 1'b1, blank: 1'b0, bcd: BCD_BLANK};
    case (pins_i)
      SEG_NUM0:  dec_o.bcd = 4'd0;
      SEG_NUM1:  dec_o.bcd = 4'd1;
      SEG_NUM2:  dec_o.bcd = 4'd2;
      SEG_NUM3:  dec_o.bcd = 4'd3;
      SEG_NUM4:  dec_o.bcd = 4'd4;
      SEG_NUM5:  dec_o.bcd = 4'd5;
      SEG_NUM6:  dec_o.bcd = 4'd6;
      SEG_NUM7:  dec_o.bcd = 4'd7;
      SEG_NUM8:  dec_o.bcd = 4'd8;
      SEG_NUM9:  dec_o.bcd = 4'd9;
      SEG_BLANK: dec_o.blank = 1'b1;
      default:   dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_receiver.sv
// Recovers the tens/ones digits from a two-digit multiplexed seven-segment bus:
// synchronize, wait for each phase to settle, decode once, hold the result.
module seg7_mux_receiver
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_mux_receiver_if.slave   bus
);

  localparam int unsigned       CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  bus_sample_t      sync1_q, sync2_q;
  bus_sample_t      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rx_state_e        state_q, state_d;
  logic             bus_change;
  logic             capture;
  seg_dec_t         dec;

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] blank_q, blank_d;
  logic       valid_q, valid_d;
  logic       update_q, update_d;
  logic       error_q, error_d;

  // Two-stage synchronizer; the bus is driven from another clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= BUS_IDLE;
      sync2_q <= BUS_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value; blocking here would collapse the two stages into one.
      sync1_q <= '{sel: bus.i_digit_sel, pins: bus.i_digit_pins};
      sync2_q <= sync1_q;
    end
  end

  assign bus_change = (sync2_q != prev_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= BUS_IDLE;
      cnt_q   <= '0;
      state_q <= ST_SETTLE;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A change on either sel or pins restarts the window; a full window fires
  // exactly one capture, after which the counter is frozen.
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    capture = 1'b0;
    if (bus_change) begin
      prev_d  = sync2_q;
      cnt_d   = '0;
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CAPTURED;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CAPTURED: ;
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  seg7_decode u_decode (
    .pins_i (prev_q.pins),
    .dec_o  (dec)
  );

  always_comb begin
    tens_d   = tens_q;
    ones_d   = ones_q;
    blank_d  = blank_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    error_d  = 1'b0;
    if (capture) begin
      if (!dec.legal) begin
        error_d = 1'b1;
      end else begin
        if (prev_q.sel) begin
          tens_d     = dec.bcd;
          blank_d[1] = dec.blank;
          update_d   = (dec.bcd != tens_q);
        end else begin
          ones_d     = dec.bcd;
          blank_d[0] = dec.blank;
          update_d   = (dec.bcd != ones_q);
        end
        valid_d = ~|blank_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q   <= BCD_BLANK;
      ones_q   <= BCD_BLANK;
      blank_q  <= 2'b11;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      blank_q  <= blank_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      error_q  <= error_d;
    end
  end

  assign bus.o_digit_tens = tens_q;
  assign bus.o_digit_ones = ones_q;
  assign bus.o_blank      = blank_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_update     = update_q;
  assign bus.o_error      = error_q;

endmodule

// File: tb/tb_seg7_mux_receiver.sv
// Bench for seg7_mux_receiver: two instances (settle 4 and 16) share one bus and
// are compared every cycle against a sample-history model plus directed checks.
module tb_seg7_mux_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       drv_sel;
  logic [6:0] drv_pins;

  always #5 clk = ~clk;

  seg7_mux_receiver_if bus4 ();
  seg7_mux_receiver_if bus16 ();

  assign bus4.i_digit_sel   = drv_sel;
  assign bus4.i_digit_pins  = drv_pins;
  assign bus16.i_digit_sel  = drv_sel;
  assign bus16.i_digit_pins = drv_pins;

  seg7_mux_receiver #(.SETTLE_CYCLES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  seg7_mux_receiver #(.SETTLE_CYCLES(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int upd_cnt [2];
  int err_cnt [2];

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference: history of bus values seen at each edge; bit 8 marks a sentinel.
  logic [8:0] hist [$];
  logic [3:0] m_tens  [2];
  logic [3:0] m_ones  [2];
  logic [1:0] m_blank [2];
  logic       m_valid [2];
  logic       m_upd   [2];
  logic       m_err   [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic int ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 15;
    for (int i = 0; i < 10; i++) if (p == seg_ref[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(9'h100);
    for (int i = 0; i < 3; i++) hist.push_back({2'b00, 7'h7F});
    for (int d = 0; d < 2; d++) begin
      m_tens[d] = 4'hF; m_ones[d] = 4'hF; m_blank[d] = 2'b11;
      m_valid[d] = 1'b0; m_upd[d] = 1'b0; m_err[d] = 1'b0;
    end
  endtask

  // A capture happens at edge e when the values seen at edges e-2-S .. e-2 are
  // all equal and the value at e-3-S differs: one capture per stable run.
  task automatic model_step(input int d);
    int         s, n, v;
    logic [8:0] base;
    bit         ok;
    s = settle_of(d);
    n = hist.size();
    m_upd[d] = 1'b0;
    m_err[d] = 1'b0;
    if (n < s + 4) return;
    base = hist[n-3];
    ok   = (hist[n-4-s] != base);
    for (int j = 1; j <= s; j++) if (hist[n-3-j] != base) ok = 0;
    if (!ok) return;
    v = ref_decode(base[6:0]);
    if (v < 0) begin
      m_err[d] = 1'b1;
    end else begin
      if (base[7]) begin
        m_upd[d]      = (int'(m_tens[d]) != v);
        m_tens[d]     = 4'(v);
        m_blank[d][1] = (v == 15);
      end else begin
        m_upd[d]      = (int'(m_ones[d]) != v);
        m_ones[d]     = 4'(v);
        m_blank[d][0] = (v == 15);
      end
      m_valid[d] = ~|m_blank[d];
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    string p;
    p = (d == 0) ? "s4" : "s16";
    chk({p, ".tens"},   8'((d == 0) ? bus4.o_digit_tens : bus16.o_digit_tens), 8'(m_tens[d]));
    chk({p, ".ones"},   8'((d == 0) ? bus4.o_digit_ones : bus16.o_digit_ones), 8'(m_ones[d]));
    chk({p, ".blank"},  8'((d == 0) ? bus4.o_blank      : bus16.o_blank),      8'(m_blank[d]));
    chk({p, ".valid"},  8'((d == 0) ? bus4.o_valid      : bus16.o_valid),      8'(m_valid[d]));
    chk({p, ".update"}, 8'((d == 0) ? bus4.o_update     : bus16.o_update),     8'(m_upd[d]));
    chk({p, ".error"},  8'((d == 0) ? bus4.o_error      : bus16.o_error),      8'(m_err[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      hist.push_back({1'b0, drv_sel, drv_pins});
      if (hist.size() > 48) void'(hist.pop_front());
      for (int d = 0; d < 2; d++) model_step(d);
    end
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    if (bus4.o_update)  upd_cnt[0]++;
    if (bus16.o_update) upd_cnt[1]++;
    if (bus4.o_error)   err_cnt[0]++;
    if (bus16.o_error)  err_cnt[1]++;
  endtask

  task automatic drive(input logic sel, input logic [6:0] pins, input int cycles);
    drv_sel  = sel;
    drv_pins = pins;
    repeat (cycles) tick();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin upd_cnt[d] = 0; err_cnt[d] = 0; end
  endtask

  initial begin
    reset    = 1'b1;
    drv_sel  = 1'b0;
    drv_pins = 7'h7F;
    model_reset();
    clear_counts();
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    repeat (3) tick();
    reset = 1'b0;

    // Idle blank bus: reset state held, no pulses.
    drive(1'b0, 7'h7F, 20);
    chk("idle_upd_pulses", 8'(upd_cnt[0] + upd_cnt[1]), 8'd0);
    chk("idle_err_pulses", 8'(err_cnt[0] + err_cnt[1]), 8'd0);
    chk("idle_blank", 8'(bus4.o_blank), 8'b11);

    // Ones = 5: pulse lands exactly at edge k+6 for settle 4.
    drive(1'b0, 7'h12, 6);
    chk("lat_before_k6", 8'(bus4.o_update), 8'd0);
    tick();
    chk("lat_at_k6_upd",   8'(bus4.o_update),     8'd1);
    chk("lat_at_k6_ones",  8'(bus4.o_digit_ones), 8'd5);
    chk("lat_at_k6_valid", 8'(bus4.o_valid),      8'd0);
    tick();
    chk("lat_pulse_end", 8'(bus4.o_update), 8'd0);
    repeat (20) tick();

    // Tens = 3 completes a valid pair.
    drive(1'b1, 7'h30, 24);
    chk("tens3", 8'(bus4.o_digit_tens), 8'd3);
    chk("tens3_valid", 8'(bus4.o_valid), 8'd1);

    // Short glitch on the ones phase.
    drive(1'b0, 7'h12, 24);
    clear_counts();
    drive(1'b0, 7'h00, 3);
    drive(1'b0, 7'h12, 24);
    chk("glitch_upd", 8'(upd_cnt[0]), 8'd0);
    chk("glitch_err", 8'(err_cnt[0]), 8'd0);
    chk("glitch_ones", 8'(bus4.o_digit_ones), 8'd5);

    // Illegal pattern held on ones.
    clear_counts();
    drive(1'b0, 7'h55, 24);
    chk("illegal_err4",  8'(err_cnt[0]), 8'd1);
    chk("illegal_err16", 8'(err_cnt[1]), 8'd1);
    chk("illegal_ones",  8'(bus4.o_digit_ones), 8'd5);
    chk("illegal_valid", 8'(bus4.o_valid), 8'd1);

    // Blank on tens.
    clear_counts();
    drive(1'b1, 7'h7F, 24);
    chk("blank_tens",  8'(bus4.o_digit_tens), 8'hF);
    chk("blank_bit",   8'(bus4.o_blank[1]), 8'd1);
    chk("blank_valid", 8'(bus4.o_valid), 8'd0);
    chk("blank_upd",   8'(upd_cnt[0]), 8'd1);

    // Asynchronous reset two cycles into the next window.
    drive(1'b0, 7'h12, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tens",  8'(bus4.o_digit_tens), 8'hF);
    chk("async_rst_ones",  8'(bus4.o_digit_ones), 8'hF);
    chk("async_rst_blank", 8'(bus4.o_blank), 8'b11);
    chk("async_rst_valid", 8'(bus4.o_valid), 8'd0);
    repeat (3) tick();
    reset = 1'b0;
    drive(1'b0, 7'h12, 24);

    // Free-running multiplex from reset: tens = 4, ones = 7.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_counts();
    for (int p = 0; p < 6; p++) begin
      if (p % 2 == 0) drive(1'b1, 7'h19, 100);
      else            drive(1'b0, 7'h78, 100);
    end
    chk("mux_upd16", 8'(upd_cnt[1]), 8'd2);
    chk("mux_upd4",  8'(upd_cnt[0]), 8'd2);
    chk("mux_tens",  8'(bus16.o_digit_tens), 8'd4);
    chk("mux_ones",  8'(bus16.o_digit_ones), 8'd7);
    chk("mux_valid", 8'(bus16.o_valid), 8'd1);

    // Randomized bursts mixing legal, blank and arbitrary patterns.
    for (int i = 0; i < 60; i++) begin
      int         kind;
      logic [6:0] pat;
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       pat = seg_ref[$urandom_range(0, 9)];
      else if (kind == 7) pat = 7'h7F;
      else                pat = 7'($urandom);
      drive(1'($urandom_range(0, 1)), pat, int'($urandom_range(1, 25)));
    end
    drive(1'b0, 7'h40, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
